// File: rtl/acia_ctrl.sv
// Bus-side sequencer for the ACIA: programs the control register, polls status,
// hands received bytes to a valid/ready register and arbitrates two TX requesters.
module acia_ctrl #(
  parameter logic [7:0] CTRL_INIT = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  output logic       acia_cs,
  output logic       acia_we,
  output logic       acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  output logic       init_done,
  input  logic [7:0] tx0_data,
  input  logic       tx0_valid,
  output logic       tx0_ready,
  input  logic [7:0] tx1_data,
  input  logic       tx1_valid,
  output logic       tx1_ready,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       rx_valid,
  input  logic       rx_ready
);

  typedef enum logic [2:0] {
    INIT_RST, INIT_CFG, POLL, STAT, RX_RD, RX_CAP, TX_WR
  } state_t;

  state_t state, state_nx;
  logic   last_grant, grant_nx;
  logic   take_rx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    grant_nx = last_grant;
    take_rx  = 1'b0;
    case (state)
      INIT_RST: state_nx = INIT_CFG;
      INIT_CFG: state_nx = POLL;
      POLL:     state_nx = STAT;
      STAT: begin
        if (acia_dout[0] && !rx_valid) begin
          take_rx  = 1'b1;
          state_nx = RX_RD;
        end else if (acia_dout[1] && (tx0_valid || tx1_valid)) begin
          state_nx = TX_WR;
          // On a tie the requester not served last time wins.
          grant_nx = (tx0_valid && tx1_valid) ? ~last_grant : tx1_valid;
        end else begin
          state_nx = POLL;
        end
      end
      RX_RD:    state_nx = RX_CAP;
      RX_CAP:   state_nx = POLL;
      TX_WR:    state_nx = POLL;
      default:  state_nx = INIT_RST;
    endcase
  end

  // Bus strobes are held low while rst is high, whatever the state register holds.
  always_comb begin
    acia_cs   = 1'b0;
    acia_we   = 1'b0;
    acia_rs   = 1'b0;
    acia_din  = 8'h00;
    tx0_ready = 1'b0;
    tx1_ready = 1'b0;
    if (!rst) begin
      case (state)
        INIT_RST: begin
          acia_cs  = 1'b1;
          acia_we  = 1'b1;
          acia_din = 8'h03;
        end
        INIT_CFG: begin
          acia_cs  = 1'b1;
          acia_we  = 1'b1;
          acia_din = CTRL_INIT;
        end
        POLL:  acia_cs = 1'b1;
        RX_RD: begin
          acia_cs = 1'b1;
          acia_rs = 1'b1;
        end
        TX_WR: begin
          acia_cs   = 1'b1;
          acia_we   = 1'b1;
          acia_rs   = 1'b1;
          acia_din  = last_grant ? tx1_data : tx0_data;
          tx0_ready = ~last_grant;
          tx1_ready = last_grant;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_RST;
      last_grant <= 1'b1;
      init_done  <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      rx_err     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= grant_nx;
      if (state == INIT_CFG) init_done <= 1'b1;
      if (take_rx) rx_err <= acia_dout[4];
      if (state == RX_CAP) begin
        rx_data  <= acia_dout;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
